// File: rtl/vbuf_responder.sv
// Burst read/write responder over an internal 2^AW x 128 synchronous RAM.
// Optional random stalling of IDLE/WBURST via macro VBUF_RESP_STALL_EN (16-bit LFSR).
module vbuf_responder #(
  parameter int unsigned AW = 10
) (
  input  logic         clk_vbuf,
  input  logic         reset,
  input  logic [27:0]  vbuf_address,
  input  logic [7:0]   vbuf_burstcount,
  input  logic [127:0] vbuf_writedata,
  input  logic [15:0]  vbuf_byteenable,
  input  logic         vbuf_read,
  input  logic         vbuf_write,
  output logic         vbuf_waitrequest,
  output logic [127:0] vbuf_readdata,
  output logic         vbuf_readdatavalid,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_e;

  state_e          state_q, state_d;
  logic [7:0]      remaining_q, remaining_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            err_q, err_d;
  logic            rdv_q, rdv_d;
  logic [127:0]    readdata_q, readdata_d;
  logic            rst_done_q;
  logic            stall;
  logic            accept;
  logic [7:0]      bc_eff;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr;

  logic [127:0]    mem [2**AW];

  generate
    if (AW < 28) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^vbuf_address[27:AW];
    end
  endgenerate

`ifdef VBUF_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_vbuf or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // rst_done_q holds waitrequest high during reset and drops it on the first edge after release
  assign vbuf_waitrequest   = !rst_done_q || (state_q == RBURST) || stall;
  assign accept             = !vbuf_waitrequest;
  assign bc_eff             = (vbuf_burstcount == 8'd0) ? 8'd1 : vbuf_burstcount;
  assign vbuf_readdata      = readdata_q;
  assign vbuf_readdatavalid = rdv_q;
  assign err                = err_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    err_d       = err_q;
    rdv_d       = 1'b0;
    readdata_d  = readdata_q;
    ram_we      = 1'b0;
    ram_waddr   = addr_q;
    case (state_q)
      IDLE: begin
        if (accept && vbuf_write) begin
          ram_we      = 1'b1;
          ram_waddr   = vbuf_address[AW-1:0];
          addr_d      = vbuf_address[AW-1:0] + AW'(1);
          remaining_d = bc_eff - 8'd1;
          if (vbuf_burstcount == 8'd0 || vbuf_read) err_d = 1'b1;
          if (bc_eff != 8'd1) state_d = WBURST;
        end else if (accept && vbuf_read) begin
          addr_d      = vbuf_address[AW-1:0];
          remaining_d = bc_eff;
          if (vbuf_burstcount == 8'd0) err_d = 1'b1;
          state_d     = RBURST;
        end
      end
      WBURST: begin
        if (accept && vbuf_read) err_d = 1'b1;
        if (accept && vbuf_write) begin
          ram_we      = 1'b1;
          ram_waddr   = addr_q;
          addr_d      = addr_q + AW'(1);
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) state_d = IDLE;
        end
      end
      RBURST: begin
        // one extra cycle after the last issue keeps waitrequest high while the last beat is presented
        if (remaining_q != 8'd0) begin
          readdata_d  = mem[addr_q];
          rdv_d       = 1'b1;
          addr_d      = addr_q + AW'(1);
          remaining_d = remaining_q - 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_vbuf or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      rdv_q       <= 1'b0;
      readdata_q  <= '0;
      rst_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      rdv_q       <= rdv_d;
      readdata_q  <= readdata_d;
      rst_done_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk_vbuf) begin
    if (ram_we) begin
      for (int unsigned b = 0; b < 16; b++) begin
        if (vbuf_byteenable[b]) mem[ram_waddr][b*8 +: 8] <= vbuf_writedata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vbuf_responder.sv
// Directed self-checking bench for vbuf_responder (AW=10): bursts, byte enables,
// wrap-around, protocol errors and reset abort.
module tb_vbuf_responder;

  logic         clk_vbuf = 1'b0;
  logic         reset;
  logic [27:0]  vbuf_address;
  logic [7:0]   vbuf_burstcount;
  logic [127:0] vbuf_writedata;
  logic [15:0]  vbuf_byteenable;
  logic         vbuf_read;
  logic         vbuf_write;
  logic         vbuf_waitrequest;
  logic [127:0] vbuf_readdata;
  logic         vbuf_readdatavalid;
  logic         err;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  logic [127:0] model [0:1023];
  logic [127:0] last_rd;
  logic         saw_stall = 1'b0;

  vbuf_responder #(.AW(10)) dut (
    .clk_vbuf          (clk_vbuf),
    .reset             (reset),
    .vbuf_address      (vbuf_address),
    .vbuf_burstcount   (vbuf_burstcount),
    .vbuf_writedata    (vbuf_writedata),
    .vbuf_byteenable   (vbuf_byteenable),
    .vbuf_read         (vbuf_read),
    .vbuf_write        (vbuf_write),
    .vbuf_waitrequest  (vbuf_waitrequest),
    .vbuf_readdata     (vbuf_readdata),
    .vbuf_readdatavalid(vbuf_readdatavalid),
    .err               (err)
  );

  always #5 clk_vbuf = ~clk_vbuf;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int unsigned k);
    return {k ^ 32'h1234_5678, ~k, k * 32'd3, 32'hDEAD_0000 | k};
  endfunction

  task automatic model_write(input logic [9:0] a, input logic [127:0] d, input logic [15:0] be);
    for (int b = 0; b < 16; b++) if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // called at a negedge; returns at a negedge with waitrequest low (or after a bounded wait)
  task automatic wait_ready();
    int n = 0;
    while (vbuf_waitrequest !== 1'b0 && n < 50) begin
      saw_stall = 1'b1;
      @(negedge clk_vbuf);
      n++;
    end
    chk("ready", {127'd0, vbuf_waitrequest}, 128'd0);
  endtask

  task automatic wr_beat(input logic [9:0] a, input logic [7:0] bc, input logic [127:0] d,
                         input logic [15:0] be, input logic rd);
    vbuf_write = 1'b1; vbuf_read = rd;
    vbuf_address = {18'd0, a}; vbuf_burstcount = bc;
    vbuf_writedata = d; vbuf_byteenable = be;
    wait_ready();
    @(negedge clk_vbuf);
  endtask

  task automatic wr_burst(input logic [9:0] a, input int unsigned bc, input int unsigned base);
    logic [9:0] ai;
    for (int unsigned i = 0; i < bc; i++) begin
      ai = a + 10'(i);
      wr_beat(ai, 8'(bc), pat(base + i), 16'hFFFF, 1'b0);
      model_write(ai, pat(base + i), 16'hFFFF);
    end
    vbuf_write = 1'b0; vbuf_read = 1'b0;
  endtask

  task automatic rd_burst(input logic [9:0] a, input logic [7:0] bc, input int unsigned nexp);
    logic [9:0] ai;
    vbuf_read = 1'b1; vbuf_write = 1'b0;
    vbuf_address = {18'd0, a}; vbuf_burstcount = bc;
    wait_ready();
    @(negedge clk_vbuf);
    vbuf_read = 1'b0;
    chk("rd_t1_wait", {127'd0, vbuf_waitrequest}, 128'd1);
    chk("rd_t1_rdv", {127'd0, vbuf_readdatavalid}, 128'd0);
    for (int unsigned i = 0; i < nexp; i++) begin
      @(negedge clk_vbuf);
      ai = a + 10'(i);
      chk("rd_rdv", {127'd0, vbuf_readdatavalid}, 128'd1);
      chk("rd_data", vbuf_readdata, model[ai]);
      chk("rd_wait_hi", {127'd0, vbuf_waitrequest}, 128'd1);
      last_rd = vbuf_readdata;
    end
    @(negedge clk_vbuf);
    chk("rd_end_rdv", {127'd0, vbuf_readdatavalid}, 128'd0);
    chk("rd_end_wait", {127'd0, vbuf_waitrequest}, 128'd0);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #1;
    chk("rst_err", {127'd0, err}, 128'd0);
    chk("rst_rdv", {127'd0, vbuf_readdatavalid}, 128'd0);
    chk("rst_wait", {127'd0, vbuf_waitrequest}, 128'd1);
    @(negedge clk_vbuf);
    reset = 1'b0;
    @(negedge clk_vbuf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; vbuf_read = 1'b0; vbuf_write = 1'b0;
    vbuf_address = '0; vbuf_burstcount = '0; vbuf_writedata = '0; vbuf_byteenable = '0;
    repeat (2) @(negedge clk_vbuf);
    chk("reset_wait", {127'd0, vbuf_waitrequest}, 128'd1);
    chk("reset_rdv", {127'd0, vbuf_readdatavalid}, 128'd0);
    chk("reset_rdata", vbuf_readdata, 128'd0);
    chk("reset_err", {127'd0, err}, 128'd0);
    reset = 1'b0;
    #1;
    chk("release_wait_hold", {127'd0, vbuf_waitrequest}, 128'd1);
    @(negedge clk_vbuf);
    chk("release_wait_low", {127'd0, vbuf_waitrequest}, 128'd0);

    // 4-beat write then read back
    wr_burst(10'h010, 4, 0);
    rd_burst(10'h010, 8'd4, 4);
    chk("s1_err", {127'd0, err}, 128'd0);

    // byte-enable partial overwrite
    wr_beat(10'h005, 8'd1, '1, 16'hFFFF, 1'b0);
    model_write(10'h005, '1, 16'hFFFF);
    wr_beat(10'h005, 8'd1, '0, 16'h0001, 1'b0);
    model_write(10'h005, '0, 16'h0001);
    vbuf_write = 1'b0;
    rd_burst(10'h005, 8'd1, 1);
    chk("s2_literal", last_rd, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00);

    // address wrap
    wr_burst(10'h3FE, 3, 100);
    rd_burst(10'h3FE, 8'd3, 3);
    rd_burst(10'h000, 8'd1, 1);
    chk("s3_word0", last_rd, pat(102));

    // read in the cycle right after a write to the same address
    wr_burst(10'h020, 1, 200);
    rd_burst(10'h020, 8'd1, 1);
    chk("raw_data", last_rd, pat(200));

    // simultaneous read and write in IDLE
    vbuf_write = 1'b1; vbuf_read = 1'b1;
    vbuf_address = 28'h30; vbuf_burstcount = 8'd1;
    vbuf_writedata = pat(50); vbuf_byteenable = 16'hFFFF;
    @(negedge clk_vbuf);
    vbuf_write = 1'b0; vbuf_read = 1'b0;
    model_write(10'h030, pat(50), 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      chk("rw_no_rdv", {127'd0, vbuf_readdatavalid}, 128'd0);
      @(negedge clk_vbuf);
    end
    chk("rw_err", {127'd0, err}, 128'd1);
    chk("rw_wait", {127'd0, vbuf_waitrequest}, 128'd0);
    reset_pulse();
    rd_burst(10'h030, 8'd1, 1);

    // burstcount 0 treated as 1
    chk("bc0_err_pre", {127'd0, err}, 128'd0);
    rd_burst(10'h010, 8'd0, 1);
    chk("bc0_err", {127'd0, err}, 128'd1);
    reset_pulse();

    // read during a write burst
    wr_beat(10'h060, 8'd2, pat(60), 16'hFFFF, 1'b0);
    model_write(10'h060, pat(60), 16'hFFFF);
    wr_beat(10'h060, 8'd2, pat(61), 16'hFFFF, 1'b1);
    model_write(10'h061, pat(61), 16'hFFFF);
    vbuf_write = 1'b0; vbuf_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wb_rd_no_rdv", {127'd0, vbuf_readdatavalid}, 128'd0);
      @(negedge clk_vbuf);
    end
    chk("wb_rd_err", {127'd0, err}, 128'd1);
    reset_pulse();
    rd_burst(10'h060, 8'd2, 2);

    // reset after the 2nd of 8 read beats
    wr_burst(10'h040, 8, 300);
    vbuf_read = 1'b1; vbuf_address = 28'h40; vbuf_burstcount = 8'd8;
    wait_ready();
    @(negedge clk_vbuf);
    vbuf_read = 1'b0;
    @(negedge clk_vbuf);
    @(negedge clk_vbuf);
    chk("abort_beat2_rdv", {127'd0, vbuf_readdatavalid}, 128'd1);
    chk("abort_beat2_data", vbuf_readdata, pat(301));
    reset = 1'b1;
    #1;
    chk("abort_rdv_now", {127'd0, vbuf_readdatavalid}, 128'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_vbuf);
      chk("abort_rdv_hold", {127'd0, vbuf_readdatavalid}, 128'd0);
    end
    reset = 1'b0;
    #1;
    chk("abort_wait_hold", {127'd0, vbuf_waitrequest}, 128'd1);
    @(negedge clk_vbuf);
    chk("abort_wait_low", {127'd0, vbuf_waitrequest}, 128'd0);
    chk("abort_rdv_after", {127'd0, vbuf_readdatavalid}, 128'd0);
    rd_burst(10'h040, 8'd8, 8);

    // long bursts
    saw_stall = 1'b0;
    wr_burst(10'h100, 64, 500);
`ifdef VBUF_RESP_STALL_EN
    chk("stall_seen", {127'd0, saw_stall}, 128'd1);
`endif
    rd_burst(10'h100, 8'd64, 64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
